button_counter: RTL and testbench

Input-side counterpart to the LED display path. It synchronises and debounces the two active-low Tang Nano 9K user buttons and turns presses into up/down steps of a 4-bit wrap-around counter, with auto-repeat while a button is held. Its `count` output is the 4-bit value consumed by the LED display block; it sits between the board button pins and that block.

---
 rtl/button_counter.sv | 122 ++++++++++++
 tb/tb_button_counter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/button_counter.sv
// rtl/button_counter.sv - debounced up/down buttons driving a 4-bit wrap counter with auto-repeat
module button_counter #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int REPEAT_DELAY    = 13500000,
  parameter int REPEAT_RATE     = 2700000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       btn_up_n,
  input  logic       btn_down_n,
  output logic [3:0] count,
  output logic       step,
  output logic       dir
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX + 1) + 1;

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] RD_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RR_LAST = TW'(REPEAT_RATE - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DELAY  = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;
  localparam logic [1:0] LOCK   = 2'd3;

  // bit 0 = up button, bit 1 = down button; all levels are active-high "pressed"
  logic [1:0]    sync1, sync2, s, s_prev;
  logic [DW-1:0] db_cnt [2];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1  <= '0;
      sync2  <= '0;
      s      <= '0;
      s_prev <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1  <= {~btn_down_n, ~btn_up_n};
      sync2  <= sync1;
      s_prev <= s;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != s[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            s[i]      <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic [1:0]    rise;
  logic          act_lvl, oth_lvl;
  logic [TW-1:0] limit;

  assign rise = s & ~s_prev;

  // While held, dir already names the active button since the first step set it
  always_comb begin
    act_lvl = dir ? s[0] : s[1];
    oth_lvl = dir ? s[1] : s[0];
    limit   = (state == DELAY) ? RD_LAST : RR_LAST;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      timer <= '0;
      count <= '0;
      step  <= 1'b0;
      dir   <= 1'b1;
    end else begin
      step <= 1'b0;
      case (state)
        IDLE: begin
          if (s[0] && s[1]) begin
            state <= LOCK;
          end else if (rise[0]) begin
            count <= count + 4'd1;
            dir   <= 1'b1;
            step  <= 1'b1;
            timer <= '0;
            state <= DELAY;
          end else if (rise[1]) begin
            count <= count - 4'd1;
            dir   <= 1'b0;
            step  <= 1'b1;
            timer <= '0;
            state <= DELAY;
          end
        end
        DELAY, REPEAT: begin
          if (!act_lvl) begin
            state <= IDLE;
          end else if (oth_lvl) begin
            state <= LOCK;
          end else if (timer == limit) begin
            count <= dir ? count + 4'd1 : count - 4'd1;
            step  <= 1'b1;
            timer <= '0;
            state <= REPEAT;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          if (s == 2'b00) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_counter.sv
// tb/tb_button_counter.sv - scoreboard bench for button_counter against a behavioural model
module tb_button_counter;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic       clk;
  logic       sys_rst;
  logic       up_n, dn_n;
  logic [3:0] count;
  logic       step;
  logic       dir;

  button_counter #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .btn_up_n(up_n), .btn_down_n(dn_n),
    .count(count), .step(step), .dir(dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int c; int v; bit d; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nsteps = 0;
  int last_step_cyc = -1;

  // Reference model: delay line for the synchroniser, run lengths for debounce,
  // and press-age arithmetic for the repeat schedule.
  bit r1 [2], r2 [2], ms [2], msp [2], lastq [2];
  int run [2];
  int mmode;            // 0 idle, 1 held, 2 locked
  bit mup;
  int mstart;
  int mcount;
  bit mdir;
  int age;
  bit a_lvl, o_lvl;

  function automatic void emit(input bit up);
    exp_t e;
    mcount = (mcount + (up ? 1 : 15)) % 16;
    mdir   = up;
    e.c = cyc; e.v = mcount; e.d = mdir;
    sb.push_back(e);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (sys_rst) begin
      for (int b = 0; b < 2; b++) begin
        r1[b] = 0; r2[b] = 0; ms[b] = 0; msp[b] = 0; lastq[b] = 0; run[b] = 0;
      end
      mmode = 0; mcount = 0; mdir = 1; mup = 1; mstart = 0;
    end else begin
      case (mmode)
        0: begin
          if (ms[0] && ms[1]) mmode = 2;
          else if (ms[0] && !msp[0]) begin emit(1); mmode = 1; mup = 1; mstart = cyc; end
          else if (ms[1] && !msp[1]) begin emit(0); mmode = 1; mup = 0; mstart = cyc; end
        end
        1: begin
          a_lvl = mup ? ms[0] : ms[1];
          o_lvl = mup ? ms[1] : ms[0];
          age   = cyc - mstart;
          if (!a_lvl) mmode = 0;
          else if (o_lvl) mmode = 2;
          else if (age == RD || (age > RD && (age - RD) % RR == 0)) emit(mup);
        end
        default: if (!ms[0] && !ms[1]) mmode = 0;
      endcase
      for (int b = 0; b < 2; b++) begin
        msp[b] = ms[b];
        if (r2[b] == lastq[b]) run[b]++;
        else begin lastq[b] = r2[b]; run[b] = 1; end
        if (r2[b] != ms[b] && run[b] >= D) ms[b] = r2[b];
        r2[b] = r1[b];
      end
      r1[0] = !up_n;
      r1[1] = !dn_n;
    end
  end

  bit   prev_step = 0;
  exp_t got;

  always @(negedge clk) begin
    if (step) begin
      nsteps++;
      last_step_cyc = cyc;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_step cyc=%0d count=%0d dir=%0d (none expected)", cyc, count, dir);
      end else begin
        got = sb.pop_front();
        if (got.c != cyc || got.v != int'(count) || got.d != dir) begin
          errors++;
          $display("FAIL step_match cyc=%0d count=%0d dir=%0d expected cyc=%0d count=%0d dir=%0d",
                   cyc, count, dir, got.c, got.v, got.d);
        end
      end
      if (prev_step) begin
        errors++;
        $display("FAIL step_consecutive cyc=%0d got two high cycles, expected isolated pulse", cyc);
      end
    end else if (sb.size() > 0 && sb[0].c <= cyc) begin
      checks++;
      errors++;
      got = sb.pop_front();
      $display("FAIL missed_step cyc=%0d step=0 expected step at cyc=%0d count=%0d", cyc, got.c, got.v);
    end
    prev_step = step;
  end

  task automatic wcyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  int base, n0, rst_edge;

  initial begin
    sys_rst = 1'b1; up_n = 1'b1; dn_n = 1'b1;
    wcyc(3);
    chk("reset_count", int'(count), 0);
    chk("reset_step", int'(step), 0);
    chk("reset_dir", int'(dir), 1);
    sys_rst = 1'b0;
    wcyc(2);

    // clean up press
    base = cyc; up_n = 1'b0;
    wcyc(10); up_n = 1'b1;
    wcyc(20);
    chk("clean_count", int'(count), 1);
    chk("clean_latency", last_step_cyc, base + D + 3);
    chk("clean_nsteps", nsteps, 1);

    // glitchy up press
    up_n = 1'b0; wcyc(3); up_n = 1'b1; wcyc(1);
    base = cyc; up_n = 1'b0;
    wcyc(10); up_n = 1'b1;
    wcyc(20);
    chk("glitch_count", int'(count), 2);
    chk("glitch_latency", last_step_cyc, base + D + 3);

    // wrap in both directions from a fresh reset
    sys_rst = 1'b1; wcyc(1); sys_rst = 1'b0; wcyc(2);
    chk("rst2_count", int'(count), 0);
    dn_n = 1'b0; wcyc(10); dn_n = 1'b1; wcyc(20);
    chk("wrap_down_count", int'(count), 15);
    chk("wrap_down_dir", int'(dir), 0);
    up_n = 1'b0; wcyc(10); up_n = 1'b1; wcyc(20);
    chk("wrap_up_count", int'(count), 0);
    chk("wrap_up_dir", int'(dir), 1);

    // auto-repeat: released so the FSM sees it just before the t+60 repeat
    n0 = nsteps; base = cyc; up_n = 1'b0;
    wcyc(D + 3 + 53); up_n = 1'b1;
    wcyc(30);
    chk("repeat_nsteps", nsteps - n0, 6);
    chk("repeat_count", int'(count), 6);
    chk("repeat_last", last_step_cyc, base + D + 3 + 52);

    // simultaneous press locks out stepping
    n0 = nsteps; up_n = 1'b0; dn_n = 1'b0;
    wcyc(20);
    chk("lock_both_nsteps", nsteps - n0, 0);
    up_n = 1'b1; wcyc(20);
    chk("lock_one_nsteps", nsteps - n0, 0);
    dn_n = 1'b1; wcyc(20);
    dn_n = 1'b0; wcyc(10); dn_n = 1'b1; wcyc(20);
    chk("lock_exit_nsteps", nsteps - n0, 1);
    chk("lock_exit_count", int'(count), 5);

    // reset while repeating with the button held
    up_n = 1'b0;
    wcyc(D + 3 + 25);
    sys_rst = 1'b1; wcyc(1);
    rst_edge = cyc;
    chk("midrst_count", int'(count), 0);
    chk("midrst_step", int'(step), 0);
    chk("midrst_dir", int'(dir), 1);
    sys_rst = 1'b0;
    wcyc(15);
    chk("midrst_latency", last_step_cyc, rst_edge + D + 3);
    chk("midrst_after", int'(count), 1);
    up_n = 1'b1; wcyc(20);

    // random segments
    for (int k = 0; k < 60; k++) begin
      up_n = 1'($urandom_range(0, 1));
      dn_n = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      wcyc(int'($urandom_range(1, 40)));
    end
    up_n = 1'b1; dn_n = 1'b1;
    wcyc(40);
    chk("random_count", int'(count), mcount);
    chk("queue_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
